bk_limb_adder: RTL and testbench
================================

# bk_limb_adder

Multi-limb add/subtract unit for the modular-exponentiation datapath. It takes wide operands as a stream of LIMB_W-bit limbs, least-significant limb first. Each limb is summed by a Brent-Kung prefix carry network: generate/propagate, an up-sweep and down-sweep tree, and XOR sum logic. The limb carry is held in a register between beats, so operands of arbitrary length are processed at one limb per cycle behind a valid/ready stream interface.

## Interface

Parameters:
- LIMB_W, 32, limb width in bits; power of two, 4..128.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- in_valid  in  1  input beat offered.
- in_ready  out  1  unit can accept a beat this cycle.
- in_first  in  1  beat is the least-significant limb of a new operation.
- in_last  in  1  beat is the most-significant limb of the operation.
- in_sub  in  1  operation mode; sampled only on the in_first beat. 0 = A+B, 1 = A−B.
- in_a  in  LIMB_W  limb of operand A.
- in_b  in  LIMB_W  limb of operand B.
- out_valid  out  1  result limb present.
- out_ready  in  1  downstream accepts the result limb.
- out_sum  out  LIMB_W  result limb.
- out_last  out  1  result limb is the final limb of the operation.
- out_cout  out  1  final carry; meaningful only when out_last=1. Add: carry-out. Sub: 1 = no borrow (A≥B).
- err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation

- Input acceptance: a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a single output register with no skid buffer.
- FSM states: IDLE and BUSY.
  - IDLE, accepted beat with in_first=1: latch mode from in_sub. Carry-in = in_sub. Go to BUSY, or stay in IDLE if in_last=1.
  - IDLE, accepted beat with in_first=0: the beat is discarded, no output is produced, and err is set.
  - BUSY, accepted beat with in_first=0: carry-in = carry register. If in_last=1, go to IDLE.
  - BUSY, accepted beat with in_first=1: the current operation is abandoned and err is set. The beat is processed as a new operation's first limb, exactly as in IDLE.
- Limb arithmetic:
  - Effective B = mode ? ~in_b : in_b.
  - {cout, sum} = in_a + Beff + cin, computed by the Brent-Kung prefix network in log2(LIMB_W) up-sweep levels plus down-sweep levels.
  - The full LIMB_W+1-bit result is kept; nothing is truncated except as split into sum and cout.
- Carry register: loaded with the limb cout on every processed beat. It is cleared to 0 when a last beat is processed.
- Output register: loaded on every processed beat with out_sum=sum, out_last=in_last, and out_cout=(in_last ? cout : 0).
- out_valid behaviour:
  - Set on a processed beat.
  - Cleared when out_ready=1 and no new beat is processed that cycle.
- Simultaneous output drain and new beat: the new result overwrites the register and out_valid stays 1.
- Discarded beats, including the IDLE in_first=0 case, leave the output register unchanged.

## Timing

- Latency: a beat accepted at edge k appears on out_* immediately after edge k. The result is registered, with one cycle of latency.
- Throughput: one limb per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. Output and carry state hold unchanged.
- Output stability: out_sum, out_last and out_cout are stable while out_valid=1 and out_ready=0.
- Reset (rst_n=0 at an edge) applies regardless of any operation in flight:
  - state = IDLE, carry = 0, mode = 0.
  - out_valid = 0, out_sum = 0, out_last = 0, out_cout = 0, err = 0.
  - Consequently in_ready = 1 in the first cycle after reset.
- Combinational paths: the only input-to-output path is out_ready → in_ready. The prefix network lies between the input ports and the output register only.

## Test plan

Run with LIMB_W=8.

1. Single-limb add: first=last=1, sub=0, a=0xFF, b=0x01 → one cycle later out_valid=1, out_sum=0x00, out_last=1, out_cout=1.
2. Three-limb add: 0x01FFFF + 0x000001, sent as limb pairs (FF,01), (FF,00), (01,00) → out_sum sequence 0x00, 0x00, 0x02; out_cout=0 on the last limb; one limb per cycle with out_ready held high.
3. Subtract, two limbs:
   - 0x0100 − 0x0001, sent as (00,01), (01,00) → 0xFF, 0x00 with out_cout=1.
   - Then 0x0000 − 0x0001 → 0xFF, 0xFF with out_cout=0.
   - The carry register must not leak between the two operations.
4. Backpressure: during test 2, hold out_ready=0 for 3 cycles after the first result → in_ready=0, out_sum=0x00 held, no limb lost or duplicated. Final results are still 0x00, 0x00, 0x02.
5. Protocol errors:
   - Send an in_first=0 beat in IDLE → no out_valid, err=1.
   - Then send in_first=1 in the middle of a three-limb operation → the new operation's results are correct with carry-in restarted, and err stays 1.
6. Reset mid-operation: assert rst_n=0 for one edge after limb 1 of test 2 → all outputs 0 and in_ready=1. A following single-limb add 0x01+0x01 gives 0x02 with out_cout=0, with no stale carry.

Source files
------------

// File: rtl/bk_limb_adder_if.sv
// Limb stream bundle for bk_limb_adder: input beats, result beats
// and the sticky protocol-error flag.
interface bk_limb_adder_if #(
  parameter int LIMB_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic              in_last;
  logic              in_sub;
  logic [LIMB_W-1:0] in_a;
  logic [LIMB_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [LIMB_W-1:0] out_sum;
  logic              out_last;
  logic              out_cout;
  logic              err;

  modport master (
    output in_valid,
    output in_first,
    output in_last,
    output in_sub,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_last,
    input  out_cout,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_first,
    input  in_last,
    input  in_sub,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_last,
    output out_cout,
    output err
  );
endinterface

// File: rtl/bk_limb_adder.sv
// Multi-limb add/subtract, one limb per cycle, LS limb first.
// Each limb goes through a Brent-Kung prefix carry tree.
module bk_limb_adder #(
  parameter int LIMB_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  bk_limb_adder_if.slave bus
);
  localparam int LVL  = $clog2(LIMB_W);
  localparam int NSTG = 2 * LVL;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state;
  logic              carry_q;
  logic              mode_q;
  logic              out_valid_q;
  logic [LIMB_W-1:0] out_sum_q;
  logic              out_last_q;
  logic              out_cout_q;
  logic              err_q;

  logic accept;
  logic take_first;
  logic take_next;
  logic process;
  logic bad_beat;
  logic mode_eff;
  logic cin;

  logic [LIMB_W-1:0] b_eff;
  logic [LIMB_W-1:0] sum;
  logic              cout;

  logic [NSTG-1:0][LIMB_W-1:0] g_t;
  logic [NSTG-1:0][LIMB_W-1:0] p_t;
  logic                        unused_p;

  assign bus.in_ready = !out_valid_q || bus.out_ready;

  assign accept     = bus.in_valid && bus.in_ready;
  assign take_first = accept && bus.in_first;
  assign take_next  = accept && !bus.in_first
                    && (state == BUSY);
  assign process    = take_first || take_next;
  assign bad_beat   = accept && (bus.in_first
                    == (state == BUSY));

  assign mode_eff = bus.in_first ? bus.in_sub : mode_q;
  assign cin      = bus.in_first ? bus.in_sub : carry_q;
  assign b_eff    = mode_eff ? ~bus.in_b : bus.in_b;

  // Carry-in is folded into bit 0's generate, so every prefix
  // G term is directly the carry out of that bit.
  always_comb begin
    g_t[0]    = bus.in_a & b_eff;
    p_t[0]    = bus.in_a ^ b_eff;
    g_t[0][0] = (bus.in_a[0] & b_eff[0])
              | (p_t[0][0] & cin);
  end

  for (genvar s = 1; s < NSTG; s++) begin : g_stg
    localparam bit UP = (s <= LVL);
    localparam int D  = UP ? s - 1 : 2 * LVL - 1 - s;
    localparam int SP = 1 << D;
    for (genvar i = 0; i < LIMB_W; i++) begin : g_bit
      localparam int K = i + 1;
      localparam bit CMB = UP
        ? ((K % (2 * SP)) == 0)
        : (((K % (2 * SP)) == SP) && (K >= 3 * SP));
      if (CMB) begin : g_cmb
        assign g_t[s][i] = g_t[s-1][i]
          | (p_t[s-1][i] & g_t[s-1][i-SP]);
        assign p_t[s][i] = p_t[s-1][i]
          & p_t[s-1][i-SP];
      end else begin : g_pas
        assign g_t[s][i] = g_t[s-1][i];
        assign p_t[s][i] = p_t[s-1][i];
      end
    end
  end

  assign unused_p = ^p_t[NSTG-1];
  assign sum  = p_t[0] ^ {g_t[NSTG-1][LIMB_W-2:0], cin};
  assign cout = g_t[NSTG-1][LIMB_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (process) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= sum;
        out_last_q  <= bus.in_last;
        out_cout_q  <= bus.in_last & cout;
        carry_q     <= !bus.in_last & cout;
        if (bus.in_first) mode_q <= bus.in_sub;
        unique case (1'b1)
          bus.in_last: state <= IDLE;
          default:     state <= BUSY;
        endcase
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bad_beat) err_q <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bk_limb_adder.sv
// Bench for bk_limb_adder at LIMB_W=8: directed cases plus random
// multi-limb ops checked against a wide-integer reference.
module tb_bk_limb_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bk_limb_adder_if #(.LIMB_W(W)) bus ();

  bk_limb_adder #(.LIMB_W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit first,
                       input bit last,
                       input bit sub);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_first = first;
    bus.in_last  = last;
    bus.in_sub   = sub;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sub   = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  // Full-width result of an n-limb operation: A + B or A + ~B + 1
  function automatic logic [64:0] ref_op(input int n,
                                         input logic [63:0] a,
                                         input logic [63:0] b,
                                         input bit sub);
    logic [64:0] m;
    logic [64:0] ae;
    logic [64:0] be;
    m  = (65'h1 << (W * n)) - 65'h1;
    ae = {1'b0, a} & m;
    be = {1'b0, sub ? ~b : b} & m;
    return ae + be + 65'(sub);
  endfunction

  task automatic run_op(input int n,
                        input logic [63:0] a,
                        input logic [63:0] b,
                        input bit sub,
                        input bit stall);
    logic [64:0] r;
    bit last;
    r = ref_op(n, a, b, sub);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      drive(a[W*i +: W], b[W*i +: W], i == 0, last, sub);
      tick();
      chk("valid", 64'(bus.out_valid), 64'd1);
      chk("sum", 64'(bus.out_sum), 64'(r[W*i +: W]));
      chk("last", 64'(bus.out_last), 64'(last));
      chk("cout", 64'(bus.out_cout),
          64'(last ? r[W*n] : 1'b0));
      if (stall && $urandom_range(0, 1) == 1) begin
        idle_in();
        bus.out_ready = 1'b0;
        tick();
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_sum", 64'(bus.out_sum), 64'(r[W*i +: W]));
        chk("stall_rdy", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
      end
    end
    idle_in();
    tick();
    chk("drained", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    idle_in();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    run_op(1, 64'hFF, 64'h01, 1'b0, 1'b0);
    run_op(3, 64'h01FFFF, 64'h000001, 1'b0, 1'b0);
    run_op(2, 64'h0100, 64'h0001, 1'b1, 1'b0);
    run_op(2, 64'h0000, 64'h0001, 1'b1, 1'b0);

    // Backpressure across the three-limb add
    bus.out_ready = 1'b1;
    drive(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_sum0", 64'(bus.out_sum), 64'h00);
    drive(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_rdy", 64'(bus.in_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold", 64'(bus.out_sum), 64'h00);
      chk("bp_hlast", 64'(bus.out_last), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_sum1", 64'(bus.out_sum), 64'h00);
    chk("bp_last1", 64'(bus.out_last), 64'd0);
    drive(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bp_sum2", 64'(bus.out_sum), 64'h02);
    chk("bp_last2", 64'(bus.out_last), 64'd1);
    chk("bp_cout", 64'(bus.out_cout), 64'd0);
    idle_in();
    tick();
    chk("bp_drain", 64'(bus.out_valid), 64'd0);

    // Stray continuation beat while idle
    drive(8'h55, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stray_valid", 64'(bus.out_valid), 64'd0);
    chk("stray_err", 64'(bus.err), 64'd1);

    // Restart in the middle of an operation with carry pending
    drive(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mid_sum0", 64'(bus.out_sum), 64'h00);
    drive(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid_sum1", 64'(bus.out_sum), 64'h00);
    run_op(2, 64'h0102, 64'h0003, 1'b0, 1'b0);
    chk("mid_err", 64'(bus.err), 64'd1);

    // Reset with a carry pending
    drive(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_sum", 64'(bus.out_sum), 64'd0);
    chk("mr_last", 64'(bus.out_last), 64'd0);
    chk("mr_cout", 64'(bus.out_cout), 64'd0);
    chk("mr_err", 64'(bus.err), 64'd0);
    chk("mr_ready", 64'(bus.in_ready), 64'd1);
    run_op(1, 64'h01, 64'h01, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 5 == 0) rb = ra;
      run_op($urandom_range(1, 8), ra, rb,
             1'($urandom_range(0, 1)), 1'b1);
    end
    chk("end_err", 64'(bus.err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
